// File: rtl/uart_pkg.sv
// Shared constants and types for the UART receive path.
package uart_pkg;
  localparam int UART_BYTE_W        = 8;
  localparam int CLK_HZ             = 27_000_000;
  localparam int BAUD               = 115200;
  localparam int UART_DELAY_FRAMES  = CLK_HZ / BAUD;
  localparam int UART_RX_FIFO_DEPTH = 16;

  typedef logic [UART_BYTE_W-1:0] uart_byte_t;
endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x byte dual-port register array: synchronous write, synchronous read.
// Only the read register is reset; the array itself holds whatever was written.
module sync_fifo_mem
  import uart_pkg::*;
#(
  parameter  int DEPTH = UART_RX_FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  uart_byte_t    wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output uart_byte_t    rdata_o
);

  uart_byte_t mem_q [DEPTH];
  uart_byte_t rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read-before-write: a same-address write this cycle is not seen until next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: edge-detected byte capture, pop
// handshake, occupancy flags and a sticky overrun flag. DEPTH must be a power of two >= 2.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = UART_RX_FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [UART_BYTE_W-1:0] byte_in,
  input  logic                   byte_valid,
  input  logic                   rd_en,
  input  logic                   clr_ovr,
  output logic [UART_BYTE_W-1:0] rd_data,
  output logic                   rd_valid,
  output logic                   empty,
  output logic                   full,
  output logic [AW:0]            count,
  output logic                   overrun
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic          valid_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          rd_valid_q;
  logic          ovr_q, ovr_d;

  logic push, pop, wr_en, drop;

  // A held strobe level counts once: only the rising edge pushes.
  assign push  = byte_valid & ~valid_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign pop   = rd_en & ~empty;
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (wr_en && !pop)      count_d = count_q + CNT_ONE;
    else if (!wr_en && pop) count_d = count_q - CNT_ONE;
    // A dropped byte in the same cycle as a clear keeps the flag set.
    ovr_d = drop | (ovr_q & ~clr_ovr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      valid_q    <= byte_valid;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= pop;
      ovr_q      <= ovr_d;
    end
  end

  sync_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (byte_in),
    .re_i    (pop),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-based reference model feeds a scoreboard that a
// free-running monitor drains on every rd_valid pulse.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] byte_in = '0;
  logic       byte_valid = 1'b0;
  logic       rd_en = 1'b0;
  logic       clr_ovr = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid, empty, full, overrun;
  logic [4:0] count;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .rd_en      (rd_en),
    .clr_ovr    (clr_ovr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] m_q[$];
  logic [7:0] exp_q[$];
  bit m_prev = 0;
  bit m_ovr  = 0;
  bit m_rv   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a bounded queue, applied at each rising edge.
  task automatic model_edge();
    bit push, pop, drop;
    push   = byte_valid && !m_prev;
    m_prev = byte_valid;
    pop    = rd_en && (m_q.size() != 0);
    m_rv   = pop;
    if (pop) exp_q.push_back(m_q.pop_front());
    drop = push && (m_q.size() >= DEPTH);
    if (push && !drop) m_q.push_back(byte_in);
    if (drop) m_ovr = 1;
    else if (clr_ovr) m_ovr = 0;
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_prev = 0;
    m_ovr  = 0;
    m_rv   = 0;
  endtask

  task automatic step(input bit bv, input logic [7:0] din, input bit re, input bit clr);
    @(negedge clk);
    byte_valid = bv;
    byte_in    = din;
    rd_en      = re;
    clr_ovr    = clr;
    @(posedge clk);
    model_edge();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    step(1, b, 0, 0);
    step(0, 8'h00, 0, 0);
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 1, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_data"},  rd_data,  0);
    chk({tag, "_empty"},    empty,    1);
    chk({tag, "_full"},     full,     0);
    chk({tag, "_count"},    count,    0);
    chk({tag, "_overrun"},  overrun,  0);
  endtask

  // Monitor: status every cycle, data whenever the DUT presents a byte.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        chk("rd_valid", rd_valid, m_rv);
        if (rd_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL rd_data_unexpected: got %0h expected no output at %0t", rd_data, $time);
          end else begin
            chk("rd_data", rd_data, exp_q.pop_front());
          end
        end
        chk("count",   count,   m_q.size());
        chk("empty",   empty,   m_q.size() == 0);
        chk("full",    full,    m_q.size() == DEPTH);
        chk("overrun", overrun, m_ovr);
      end
    end
  end

  initial begin
    logic [7:0] pat;
    int pushes;
    bit bv, re;

    #1 rst_n = 1'b0;
    #2 chk_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single byte then pop one cycle later
    step(1, 8'h41, 0, 0);
    #1;
    chk("t1_empty", empty, 0);
    chk("t1_count", count, 1);
    step(0, 8'h00, 1, 0);
    idle(2);

    // Level held for 5 cycles pushes once
    for (int i = 0; i < 5; i++) step(1, 8'h55, 0, 0);
    #1 chk("t2_count", count, 1);
    step(0, 8'h00, 0, 0);
    pop_n(2);
    idle(1);

    // Fill, overflow, drain in order
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    #1;
    chk("t3_full", full, 1);
    chk("t3_count", count, 16);
    push_byte(8'hAA);
    #1;
    chk("t3_overrun", overrun, 1);
    chk("t3_count_after_drop", count, 16);
    pop_n(16);
    idle(1);
    step(0, 8'h00, 0, 1);
    idle(1);

    // Full with simultaneous push and pop
    for (int i = 0; i < 16; i++) push_byte(8'h60 + 8'(i));
    step(1, 8'h99, 1, 0);
    #1;
    chk("t4_count", count, 16);
    chk("t4_overrun", overrun, 0);
    step(0, 8'h00, 0, 0);
    pop_n(17);
    idle(1);

    // Interleaved wrap with occupancy capped at 5
    pat = 8'h80;
    pushes = 0;
    for (int i = 0; i < 400 && pushes < 40; i++) begin
      bv = !byte_valid && (m_q.size() < 5) && ($urandom_range(0, 1) == 1);
      re = ($urandom_range(0, 2) != 0);
      step(bv, pat, re, 0);
      if (bv) begin
        pat++;
        pushes++;
      end
    end
    step(0, 8'h00, 0, 0);
    pop_n(6);
    chk("t5_pushes", pushes, 40);

    // Random traffic: fill-heavy then drain-heavy, random clears
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1) == 1, 8'($urandom), (i < 200) ? ($urandom_range(0, 3) == 0)
           : ($urandom_range(0, 2) != 0), $urandom_range(0, 15) == 0);
    step(0, 8'h00, 0, 1);
    pop_n(DEPTH + 1);

    // Clear coincident with a dropping push keeps overrun set
    for (int i = 0; i < 16; i++) push_byte(8'hC0 + 8'(i));
    step(1, 8'hAB, 0, 1);
    #1 chk("t6_overrun_set_wins", overrun, 1);
    step(0, 8'h00, 0, 0);

    // Mid-stream async reset with 3 queued and a pop in flight
    pop_n(13);
    #1;
    chk("t7_count_before", count, 3);
    chk("t7_ovr_before", overrun, 1);
    chk("t7_rv_before", rd_valid, 1);
    #1;
    rst_n      = 1'b0;
    byte_valid = 1'b0;
    rd_en      = 1'b0;
    clr_ovr    = 1'b0;
    #1 chk_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pop_n(2);
    push_byte(8'h3C);
    pop_n(2);
    idle(3);

    chk("leftover_expected", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
